// File: rtl/bus_fabric_pkg.sv
// Shared definitions for the CPU byte-bus fabric: FSM state encoding,
// default memory map and small elaboration helpers.
package bus_fabric_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2,
    ST_ERR    = 2'd3
  } bus_state_t;

  // Default memory map of the CPU system.
  localparam logic [31:0] ROM_START   = 32'h0000_0000;
  localparam logic [31:0] ROM_SIZE    = 32'h0000_1000;
  localparam logic [31:0] RAM_START   = 32'h0001_0000;
  localparam logic [31:0] RAM_SIZE    = 32'h0000_1000;
  localparam logic [31:0] UART_SEND   = 32'h0002_0000;
  localparam logic [31:0] UART_CONFIG = 32'h0002_0001;
  localparam logic [31:0] OUT_PORT    = 32'h0002_0004;

  // Slot 0 = ROM, 1 = RAM, 2 = UART data, 3 = out port.
  localparam logic [127:0] DEF_SLAVE_BASE = {OUT_PORT, UART_SEND, RAM_START, ROM_START};
  localparam logic [127:0] DEF_SLAVE_SIZE = {32'd1, 32'd1, RAM_SIZE, ROM_SIZE};

  // Index width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_addr_decoder.sv
// Combinational region decoder: per-slot range match, lowest-index priority
// encode and slave-relative offset generation.
module bus_addr_decoder
  import bus_fabric_pkg::*;
#(
  parameter int                          N_SLAVES   = 4,
  parameter int                          ADDR_W     = 32,
  parameter logic [N_SLAVES*ADDR_W-1:0]  SLAVE_BASE = DEF_SLAVE_BASE,
  parameter logic [N_SLAVES*ADDR_W-1:0]  SLAVE_SIZE = DEF_SLAVE_SIZE,
  parameter int                          IDX_W      = clog2_min1(N_SLAVES)
) (
  input  logic [ADDR_W-1:0] i_addr,
  output logic              o_hit,
  output logic [IDX_W-1:0]  o_idx,
  output logic [ADDR_W-1:0] o_offset
);

  logic [N_SLAVES-1:0]             w_match;
  logic [N_SLAVES-1:0][ADDR_W-1:0] w_off;
  logic [ADDR_W:0]                 w_addr_x;

  assign w_addr_x = {1'b0, i_addr};

  // One extra bit on the compare keeps a region ending at the top of the
  // address space from wrapping around to zero.
  for (genvar i = 0; i < N_SLAVES; i++) begin : g_slot
    localparam logic [ADDR_W-1:0] BASE  = SLAVE_BASE[i*ADDR_W +: ADDR_W];
    localparam logic [ADDR_W-1:0] SIZE  = SLAVE_SIZE[i*ADDR_W +: ADDR_W];
    localparam logic [ADDR_W:0]   LIMIT = {1'b0, BASE} + {1'b0, SIZE};
    assign w_match[i] = (SIZE != '0) && (w_addr_x >= {1'b0, BASE}) && (w_addr_x < LIMIT);
    assign w_off[i]   = i_addr - BASE;
  end

  // Priority encode: scan downward so the lowest matching index is kept.
  always_comb begin
    o_hit = 1'b0;
    o_idx = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if (w_match[i]) begin
        o_hit = 1'b1;
        o_idx = IDX_W'(i);
      end
    end
  end

  assign o_offset = w_off[o_idx];

endmodule

// File: rtl/bus_fabric.sv
// Registered address-decode / handshake fabric between the CPU byte bus and
// N memory-mapped slaves. Optional sticky error-address capture is enabled
// with BUS_FABRIC_ERR_CAPTURE_EN.
module bus_fabric
  import bus_fabric_pkg::*;
#(
  parameter int                          N_SLAVES       = 4,
  parameter int                          ADDR_W         = 32,
  parameter int                          DATA_W         = 8,
  parameter logic [N_SLAVES*ADDR_W-1:0]  SLAVE_BASE     = DEF_SLAVE_BASE,
  parameter logic [N_SLAVES*ADDR_W-1:0]  SLAVE_SIZE     = DEF_SLAVE_SIZE,
  parameter int                          TIMEOUT_CYCLES = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cpu_req,
  input  logic                       cpu_we,
  input  logic [ADDR_W-1:0]          cpu_addr,
  input  logic [DATA_W-1:0]          cpu_wdata,
  output logic                       cpu_ready,
  output logic [DATA_W-1:0]          cpu_rdata,
  output logic                       cpu_err,
  output logic [N_SLAVES-1:0]        s_sel,
  output logic                       s_we,
  output logic [ADDR_W-1:0]          s_addr,
  output logic [DATA_W-1:0]          s_wdata,
  input  logic [N_SLAVES*DATA_W-1:0] s_rdata,
  input  logic [N_SLAVES-1:0]        s_ready
`ifdef BUS_FABRIC_ERR_CAPTURE_EN
  ,
  output logic [ADDR_W-1:0]          err_addr,
  output logic                       err_valid,
  input  logic                       err_clear
`endif
);

  localparam int IDX_W = clog2_min1(N_SLAVES);
  localparam int CNT_W = clog2_min1(TIMEOUT_CYCLES);

  bus_state_t        r_state, w_state_nxt;
  logic [IDX_W-1:0]  r_idx;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_we;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;

  logic              w_hit;
  logic [IDX_W-1:0]  w_idx;
  logic [ADDR_W-1:0] w_off;
  logic              w_ready_sel;
  logic              w_timeout;
  logic              w_latch;
  logic              w_done;
  logic              w_to;
  logic              w_miss;

  bus_addr_decoder #(
    .N_SLAVES   (N_SLAVES),
    .ADDR_W     (ADDR_W),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_SIZE (SLAVE_SIZE),
    .IDX_W      (IDX_W)
  ) u_dec (
    .i_addr   (cpu_addr),
    .o_hit    (w_hit),
    .o_idx    (w_idx),
    .o_offset (w_off)
  );

  // Only the latched slot's ready matters; other slots are ignored.
  assign w_ready_sel = s_ready[r_idx];
  assign w_timeout   = (TIMEOUT_CYCLES != 0) && (32'(r_cnt) == 32'(TIMEOUT_CYCLES - 1));

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state and datapath control; slave ready beats the timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_done      = 1'b0;
    w_to        = 1'b0;
    w_miss      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cpu_req) begin
          if (w_hit) begin
            w_state_nxt = ST_ACCESS;
            w_latch     = 1'b1;
          end else begin
            w_state_nxt = ST_ERR;
            w_miss      = 1'b1;
          end
        end
      end
      ST_ACCESS: begin
        if (w_ready_sel) begin
          w_state_nxt = ST_RESP;
          w_done      = 1'b1;
        end else if (w_timeout) begin
          w_state_nxt = ST_RESP;
          w_to        = 1'b1;
        end
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      ST_ERR:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Access latch, wait counter and response capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_latch) begin
        r_idx   <= w_idx;
        r_addr  <= w_off;
        r_wdata <= cpu_wdata;
        r_we    <= cpu_we;
        r_cnt   <= '0;
      end else if (r_state == ST_ACCESS) begin
        r_cnt   <= r_cnt + 1'b1;
      end
      if (w_done) begin
        r_rdata <= r_we ? '0 : s_rdata[r_idx*DATA_W +: DATA_W];
        r_err   <= 1'b0;
      end else if (w_to) begin
        r_rdata <= '0;
        r_err   <= 1'b1;
      end
    end
  end

  // Outputs decode straight from the state register so reset drops them at once.
  assign s_sel     = (r_state == ST_ACCESS) ? (N_SLAVES'(1) << r_idx) : '0;
  assign s_we      = (r_state == ST_ACCESS) && r_we;
  assign s_addr    = r_addr;
  assign s_wdata   = r_wdata;
  assign cpu_ready = (r_state == ST_RESP) || (r_state == ST_ERR);
  assign cpu_rdata = (r_state == ST_RESP) ? r_rdata : '0;
  assign cpu_err   = ((r_state == ST_RESP) && r_err) || (r_state == ST_ERR);

`ifdef BUS_FABRIC_ERR_CAPTURE_EN
  logic [ADDR_W-1:0] r_abs_addr;
  logic [ADDR_W-1:0] r_err_addr;
  logic              r_err_valid;
  logic              w_err_evt;

  // Absolute address kept for reporting a timeout after the CPU moves on.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         r_abs_addr <= '0;
    else if (w_latch) r_abs_addr <= cpu_addr;
  end

  assign w_err_evt = w_miss || w_to;

  // Sticky first-error capture; a new error on a clearing edge wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err_addr  <= '0;
      r_err_valid <= 1'b0;
    end else if (w_err_evt && (!r_err_valid || err_clear)) begin
      r_err_addr  <= w_miss ? cpu_addr : r_abs_addr;
      r_err_valid <= 1'b1;
    end else if (err_clear) begin
      r_err_valid <= 1'b0;
    end
  end

  assign err_addr  = r_err_addr;
  assign err_valid = r_err_valid;
`endif

endmodule

// File: tb/tb_bus_fabric.sv
// Self-checking bench for bus_fabric: directed scenarios followed by random
// accesses checked against a region-table reference model.
module tb_bus_fabric;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ready, cpu_err;
  logic [7:0]  cpu_rdata;
  logic [3:0]  s_sel;
  logic        s_we;
  logic [31:0] s_addr;
  logic [7:0]  s_wdata;
  logic [31:0] s_rdata;
  logic [3:0]  s_ready;
`ifdef BUS_FABRIC_ERR_CAPTURE_EN
  logic [31:0] err_addr;
  logic        err_valid;
  logic        err_clear;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_rdy = 0;

  localparam int TMO = 16;

  // Reference memory map, independent of the RTL package.
  longint ref_base [4] = '{64'h0, 64'h10000, 64'h20000, 64'h20004};
  longint ref_size [4] = '{64'h1000, 64'h1000, 64'h1, 64'h1};

  bus_fabric dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ready (cpu_ready),
    .cpu_rdata (cpu_rdata),
    .cpu_err   (cpu_err),
    .s_sel     (s_sel),
    .s_we      (s_we),
    .s_addr    (s_addr),
    .s_wdata   (s_wdata),
    .s_rdata   (s_rdata),
    .s_ready   (s_ready)
`ifdef BUS_FABRIC_ERR_CAPTURE_EN
    ,
    .err_addr  (err_addr),
    .err_valid (err_valid),
    .err_clear (err_clear)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_slot(input logic [31:0] a);
    longint ax;
    ax = longint'({32'h0, a});
    for (int i = 0; i < 4; i++)
      if (ref_size[i] != 0 && ax >= ref_base[i] && ax < ref_base[i] + ref_size[i]) return i;
    return -1;
  endfunction

  // One CPU access; k = wait cycles before the target slave raises ready.
  task automatic do_access(input logic we, input logic [31:0] addr, input logic [7:0] wd,
                           input logic [7:0] rd, input int k, input bit hold);
    int          slot, lat;
    logic        exp_err;
    logic [7:0]  exp_rd;
    logic [31:0] exp_off;
    bit          seen;
    slot = ref_slot(addr);
    if (slot < 0) begin
      lat = 1; exp_err = 1'b1; exp_rd = 8'h0; exp_off = 32'h0;
    end else begin
      exp_off = 32'(longint'({32'h0, addr}) - ref_base[slot]);
      if (k <= TMO - 1) begin
        lat = 2 + k; exp_err = 1'b0; exp_rd = we ? 8'h0 : rd;
      end else begin
        lat = 1 + TMO; exp_err = 1'b1; exp_rd = 8'h0;
      end
    end
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    s_rdata = $urandom;
    if (slot >= 0) s_rdata[slot*8 +: 8] = rd;
    s_ready = 4'($urandom);
`ifdef BUS_FABRIC_ERR_CAPTURE_EN
    err_clear = 1'b1;
`endif
    seen = 1'b0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(posedge clk); #1;
`ifdef BUS_FABRIC_ERR_CAPTURE_EN
      err_clear = 1'b0;
`endif
      // Busy-time changes on the CPU side must be ignored.
      cpu_addr = $urandom; cpu_wdata = 8'($urandom); cpu_we = 1'($urandom);
      s_ready = 4'($urandom);
      if (slot >= 0) s_ready[slot] = (c == k + 1);
      @(negedge clk);
      if (c < lat) begin
        chk("ready_low", cpu_ready, 1'b0);
        chk("rdata_idle", cpu_rdata, 8'h0);
        chk("sel", s_sel, 4'b0001 << slot);
        chk("s_we", s_we, we);
        chk("s_addr", s_addr, exp_off);
        if (we) chk("s_wdata", s_wdata, wd);
      end else begin
        seen = 1'b1;
        last_rdy = cyc;
        chk("ready", cpu_ready, 1'b1);
        chk("err", cpu_err, exp_err);
        chk("rdata", cpu_rdata, exp_rd);
        chk("sel_resp", s_sel, 4'b0000);
`ifdef BUS_FABRIC_ERR_CAPTURE_EN
        chk("err_valid", err_valid, exp_err);
        if (exp_err) chk("err_addr", err_addr, addr);
`endif
        if (!hold) cpu_req = 1'b0;
      end
    end
    chk("completed", seen, 1'b1);
  endtask

  initial begin
    int r1;
    logic [31:0] a;
    int k, sel, pick;
    rst = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    s_rdata = '0; s_ready = '0;
`ifdef BUS_FABRIC_ERR_CAPTURE_EN
    err_clear = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", cpu_ready, 1'b0);
    chk("rst_err", cpu_err, 1'b0);
    chk("rst_rdata", cpu_rdata, 8'h0);
    chk("rst_sel", s_sel, 4'h0);
    chk("rst_we", s_we, 1'b0);
    chk("rst_addr", s_addr, 32'h0);
    chk("rst_wdata", s_wdata, 8'h0);
`ifdef BUS_FABRIC_ERR_CAPTURE_EN
    chk("rst_err_valid", err_valid, 1'b0);
`endif
    rst = 1'b1;

    // Directed scenarios.
    do_access(1'b0, 32'h0001_0010, 8'h00, 8'hA5, 0, 1'b0);
    do_access(1'b1, 32'h0002_0000, 8'h3C, 8'h77, 3, 1'b0);
    do_access(1'b0, 32'h0000_5000, 8'h00, 8'h00, 0, 1'b0);
    do_access(1'b0, 32'h0000_0100, 8'h00, 8'h11, 100, 1'b0);

    // Reset mid-access drops the select without waiting for a clock.
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0002_0004; s_ready = 4'h0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_sel", s_sel, 4'b1000);
    rst = 1'b0; #1;
    chk("mid_rst_sel", s_sel, 4'b0000);
    chk("mid_rst_ready", cpu_ready, 1'b0);
    chk("mid_rst_we", s_we, 1'b0);
    cpu_req = 1'b0;
    @(negedge clk); rst = 1'b1;
    do_access(1'b0, 32'h0002_0004, 8'h00, 8'h5A, 0, 1'b0);

    // Back-to-back with req held across both accesses.
    do_access(1'b0, 32'h0000_0000, 8'h00, 8'hC1, 0, 1'b1);
    r1 = last_rdy;
    do_access(1'b0, 32'h0000_0001, 8'h00, 8'hD2, 0, 1'b0);
    chk("b2b_spacing", last_rdy - r1, 3);

    // Boundaries: top of space, just past regions, ready on the timeout edge.
    do_access(1'b0, 32'hFFFF_FFFF, 8'h00, 8'h00, 0, 1'b0);
    do_access(1'b0, 32'h0000_1000, 8'h00, 8'h00, 0, 1'b0);
    do_access(1'b0, 32'h0001_0FFF, 8'h00, 8'h9E, 15, 1'b0);
    do_access(1'b1, 32'h0000_0FFF, 8'h42, 8'h00, 16, 1'b0);

    // Random traffic.
    for (int n = 0; n < 250; n++) begin
      sel = $urandom_range(0, 5);
      if (sel < 4) begin
        pick = $urandom_range(0, 2);
        if (pick == 0)      a = 32'(ref_base[sel]);
        else if (pick == 1) a = 32'(ref_base[sel] + ref_size[sel] - 1);
        else                a = 32'(ref_base[sel] + longint'($urandom_range(0, 32'(ref_size[sel] - 1))));
      end else if (sel == 4) begin
        pick = $urandom_range(0, 3);
        a = 32'(ref_base[pick] + ref_size[pick]);
      end else begin
        a = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      end
      pick = $urandom_range(0, 9);
      if (pick < 6)       k = pick;
      else if (pick == 6) k = 15;
      else if (pick == 7) k = 16;
      else if (pick == 8) k = $urandom_range(0, 20);
      else                k = 0;
      do_access(1'($urandom), a, 8'($urandom), 8'($urandom), k, 1'($urandom));
    end

    @(posedge clk); #1;
    cpu_req = 1'b0;
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
